// File: rtl/td4_pkg.sv
// Shared TD4 constants for the switch input conditioner.
package td4_pkg;

    localparam int unsigned DEBOUNCE_CYCLES     = 500000;
    localparam int unsigned DEBOUNCE_CYCLES_SIM = 4;
    localparam int unsigned DEBOUNCE_CNT_W      = 19;

    typedef enum logic {
        DB_STABLE   = 1'b0,
        DB_COUNTING = 1'b1
    } db_state_e;

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: 2-flop synchroniser, hold-time counter, registered level and edge pulses.
module debounce_bit
    import td4_pkg::*;
#(
    parameter int unsigned CNT_MAX = DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W   = DEBOUNCE_CNT_W
) (
    input  logic CLK,
    input  logic clr_n,
    input  logic d_raw,
    output logic q,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    logic             s1_q;
    logic             s2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             q_q;
    logic             q_d;
    logic             rise_q;
    logic             rise_d;
    logic             fall_q;
    logic             fall_d;
    db_state_e        state_c;

    // Next-state: any agreement with the held level discards a partial count.
    always_comb begin
        cnt_d   = '0;
        q_d     = q_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        state_c = (s2_q != q_q) ? DB_COUNTING : DB_STABLE;
        case (state_c)
            DB_COUNTING: begin
                if (cnt_q == CNT_LAST) begin
                    q_d    = s2_q;
                    rise_d = s2_q;
                    fall_d = ~s2_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: cnt_d = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge clr_n) begin
        if (!clr_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            cnt_q  <= '0;
            q_q    <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= d_raw;
            s2_q   <= s1_q;
            cnt_q  <= cnt_d;
            q_q    <= q_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign q    = q_q;
    assign rise = rise_q;
    assign fall = fall_q;
    // Counter occupancy after the coming edge, so the parent can register it in step.
    assign busy = (cnt_d != '0);

endmodule

// File: rtl/sw_debounce.sv
// Slide-switch conditioner for the TD4 IN port: per-bit debounce plus an all-quiet flag.
module sw_debounce
    import td4_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,
    parameter bit          USE_SIM_CNT = 1'b0,
    parameter int unsigned CNT_MAX     = USE_SIM_CNT ? DEBOUNCE_CYCLES_SIM : DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W       = DEBOUNCE_CNT_W
) (
    input  logic             CLK,
    input  logic             clr_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_db,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             stable
);

    logic [WIDTH-1:0] busy_c;
    logic             stable_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .CNT_MAX (CNT_MAX),
            .CNT_W   (CNT_W)
        ) u_bit (
            .CLK   (CLK),
            .clr_n (clr_n),
            .d_raw (sw_raw[i]),
            .q     (sw_db[i]),
            .rise  (sw_rise[i]),
            .fall  (sw_fall[i]),
            .busy  (busy_c[i])
        );
    end

    // Registered with the counters so it reflects the same edge's count values.
    always_ff @(posedge CLK or negedge clr_n) begin
        if (!clr_n) begin
            stable_q <= 1'b1;
        end else begin
            stable_q <= ~|busy_c;
        end
    end

    assign stable = stable_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Scoreboard bench for sw_debounce: directed spec scenarios plus randomized bouncing switches.
module tb_sw_debounce;

    localparam int W       = 4;
    localparam int CNT_MAX = 4;

    typedef struct packed {
        logic [W-1:0] db;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic         stable;
    } exp_t;

    logic         CLK     = 1'b0;
    logic         clr_n   = 1'b1;
    logic [W-1:0] sw_raw  = '0;
    logic [W-1:0] sw_db;
    logic [W-1:0] sw_rise;
    logic [W-1:0] sw_fall;
    logic         stable;
    bit           clk_run = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    exp_t         sb[$];
    logic [W-1:0] hist[$];
    int           k = 0;
    logic [W-1:0] m_db = '0;
    int           last_acc[W];
    exp_t         m_e;
    exp_t         mon_e;
    logic [W-1:0] win_v;
    bit           all_diff;

    logic [W-1:0] tgt;
    logic [W-1:0] v;
    logic [W-1:0] pvec;
    int           pcnt;
    int           pat;

    sw_debounce #(
        .WIDTH       (W),
        .USE_SIM_CNT (1'b1),
        .CNT_W       (3)
    ) dut (
        .CLK     (CLK),
        .clr_n   (clr_n),
        .sw_raw  (sw_raw),
        .sw_db   (sw_db),
        .sw_rise (sw_rise),
        .sw_fall (sw_fall),
        .stable  (stable)
    );

    always begin
        #5;
        if (clk_run) CLK = ~CLK;
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] raw_at(input int j);
        return (j < 0) ? '0 : hist[j];
    endfunction

    // Reference: a bit flips once its synchronised value (raw two edges back) has differed
    // from the held level on CNT_MAX consecutive evaluations since its last flip.
    always @(posedge CLK) begin
        if (!clr_n) begin
            hist.delete();
            k    = 0;
            m_db = '0;
            for (int b = 0; b < W; b++) last_acc[b] = -100;
        end else begin
            hist.push_back(sw_raw);
            m_e.rise   = '0;
            m_e.fall   = '0;
            m_e.stable = 1'b1;
            for (int b = 0; b < W; b++) begin
                all_diff = (k - CNT_MAX + 1) > last_acc[b];
                for (int i = 0; i < CNT_MAX; i++) begin
                    win_v = raw_at(k - 2 - i);
                    if (win_v[b] == m_db[b]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    m_db[b] = ~m_db[b];
                    if (m_db[b]) m_e.rise[b] = 1'b1;
                    else         m_e.fall[b] = 1'b1;
                    last_acc[b] = k;
                end else begin
                    win_v = raw_at(k - 2);
                    if (win_v[b] != m_db[b]) m_e.stable = 1'b0;
                end
            end
            m_e.db = m_db;
            sb.push_back(m_e);
            k++;
        end
    end

    // Monitor: DUT presents a new output word every cycle; compare away from the edge.
    always @(negedge CLK) begin
        if (!clr_n) begin
            chk("rst_db",     sw_db,   '0);
            chk("rst_rise",   sw_rise, '0);
            chk("rst_fall",   sw_fall, '0);
            chk("rst_stable", W'(stable), W'(1));
        end else if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("sb_db",     sw_db,   mon_e.db);
            chk("sb_rise",   sw_rise, mon_e.rise);
            chk("sb_fall",   sw_fall, mon_e.fall);
            chk("sb_stable", W'(stable), W'(mon_e.stable));
        end
    end

    task automatic drive(input logic [W-1:0] val, input int n);
        sw_raw = val;
        repeat (n) begin
            @(posedge CLK);
            #2;
        end
    endtask

    task automatic watch_rise(input logic [W-1:0] mask, input int n,
                              output int cnt, output int at, output logic [W-1:0] vec);
        cnt = 0;
        at  = -1;
        vec = '0;
        for (int i = 1; i <= n; i++) begin
            @(posedge CLK);
            #1;
            if ((sw_rise & mask) != '0) begin
                cnt++;
                at  = i;
                vec = sw_rise & mask;
            end
        end
    endtask

    initial begin
        // 1: asynchronous reset with no clock running
        sw_raw = 4'b1111;
        #1 clr_n = 1'b0;
        #2;
        chk("t1_db",     sw_db,   4'b0000);
        chk("t1_rise",   sw_rise, 4'b0000);
        chk("t1_fall",   sw_fall, 4'b0000);
        chk("t1_stable", W'(stable), W'(1));
        clk_run = 1'b1;
        repeat (3) @(posedge CLK);
        #2;
        sw_raw = 4'b0000;
        clr_n  = 1'b1;
        drive(4'b0000, 3);

        // 2: clean step to 0101
        sw_raw = 4'b0101;
        for (int i = 1; i <= 6; i++) begin
            @(posedge CLK);
            #1;
            chk("t2_db",     sw_db,   (i == 6) ? 4'b0101 : 4'b0000);
            chk("t2_rise",   sw_rise, (i == 6) ? 4'b0101 : 4'b0000);
            chk("t2_stable", W'(stable), (i >= 3 && i <= 5) ? W'(0) : W'(1));
        end
        @(posedge CLK);
        #1;
        chk("t2_rise_clr", sw_rise, 4'b0000);
        drive(4'b0000, 8);

        // 3: three-cycle glitch on bit0 is rejected
        sw_raw = 4'b0001;
        for (int i = 1; i <= 11; i++) begin
            @(posedge CLK);
            #1;
            chk("t3_db",   sw_db,   4'b0000);
            chk("t3_rise", sw_rise, 4'b0000);
            if (i == 3) sw_raw = 4'b0000;
        end
        chk("t3_stable", W'(stable), W'(1));

        // 4: bounce bit2 then hold
        drive(4'b0100, 1);
        drive(4'b0000, 1);
        drive(4'b0100, 1);
        drive(4'b0100, 1);
        drive(4'b0000, 1);
        sw_raw = 4'b0100;
        watch_rise(4'b0100, 12, pcnt, pat, pvec);
        chk_int("t4_rise_count", pcnt, 1);
        chk_int("t4_rise_edge",  pat,  6);

        // 5: all bits fall together
        drive(4'b1111, 10);
        sw_raw = 4'b0000;
        for (int i = 1; i <= 6; i++) begin
            @(posedge CLK);
            #1;
            chk("t5_db",   sw_db,   (i == 6) ? 4'b0000 : 4'b1111);
            chk("t5_fall", sw_fall, (i == 6) ? 4'b1111 : 4'b0000);
            chk("t5_rise", sw_rise, 4'b0000);
        end
        @(posedge CLK);
        #1;
        chk("t5_fall_clr", sw_fall, 4'b0000);

        // 6: reset mid-count, release with switches held high
        drive(4'b0000, 10);
        sw_raw = 4'b1111;
        repeat (4) @(posedge CLK);
        #1;
        chk("t6_pre_stable", W'(stable), W'(0));
        #2;
        clr_n = 1'b0;
        sb.delete();
        #1;
        chk("t6_db",     sw_db,   4'b0000);
        chk("t6_rise",   sw_rise, 4'b0000);
        chk("t6_stable", W'(stable), W'(1));
        repeat (2) @(posedge CLK);
        #2;
        clr_n = 1'b1;
        watch_rise(4'b1111, 12, pcnt, pat, pvec);
        chk_int("t6_rise_count", pcnt, 1);
        chk_int("t6_rise_edge",  pat,  6);
        chk("t6_rise_vec", pvec, 4'b1111);

        // Random bouncing switches with occasional asynchronous resets
        tgt = '0;
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 7) == 0) tgt = W'($urandom);
            v = tgt;
            for (int b = 0; b < W; b++)
                if ($urandom_range(0, 9) == 0) v[b] = ~v[b];
            if ($urandom_range(0, 399) == 0) begin
                clr_n = 1'b0;
                sb.delete();
                repeat (2) @(posedge CLK);
                #2;
                clr_n = 1'b1;
            end
            drive(v, 1);
        end
        drive(tgt, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
